// File: rtl/hmmm_mem_if.sv
// Unified instruction/data memory port of the HMMM core.
// The core is the master. The memory answers with a single mem_ready that allows wait states.
interface hmmm_mem_if #(
  parameter int WIDTH = 8,
  parameter int IW    = 15
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_adr;
  logic [WIDTH-1:0] mem_wdata;
  logic [IW-1:0]    mem_rdata;
  logic             mem_ready;

  modport master (
    output mem_req, mem_we, mem_adr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_adr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/hmmm_core.sv
// Multi-cycle HMMM core: FETCH -> EXEC -> (MEM) -> FETCH, with r0 hardwired to zero.
// Memory accesses use ready/valid handshaking and may take any number of wait states.
module hmmm_core #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8
) (
  input  logic       ph1,
  input  logic       reset,
  hmmm_mem_if.master mem,
  output logic       halted
);
  localparam int RB = $clog2(NREGS);
  localparam int IW = 4 + RB + WIDTH;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t                        state_q, state_d;
  logic [WIDTH-1:0]              pc_q, pc_d, pc_inc;
  logic [IW-1:0]                 ir_q, ir_d;
  logic [NREGS-1:0][WIDTH-1:0]   regs_q;

  logic [3:0]       op;
  logic [RB-1:0]    rx_idx, ry_idx, rz_idx;
  logic [WIDTH-1:0] imm, rx_v, ry_v, rz_v;
  logic             taken, wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             req, we;
  logic [WIDTH-1:0] adr, wdata;

  assign op     = ir_q[IW-1:IW-4];
  assign rx_idx = ir_q[IW-5:WIDTH];
  assign imm    = ir_q[WIDTH-1:0];
  assign ry_idx = imm[WIDTH-1 -: RB];
  assign rz_idx = imm[WIDTH-RB-1 -: RB];
  assign rx_v   = (rx_idx == '0) ? '0 : regs_q[rx_idx];
  assign ry_v   = (ry_idx == '0) ? '0 : regs_q[ry_idx];
  assign rz_v   = (rz_idx == '0) ? '0 : regs_q[rz_idx];
  assign pc_inc = pc_q + WIDTH'(1);

  always_comb begin
    taken = 1'b0;
    case (op)
      4'h8:    taken = (rx_v == '0);
      4'h9:    taken = (rx_v != '0);
      4'hA:    taken = !rx_v[WIDTH-1] && (rx_v != '0);
      4'hB:    taken = rx_v[WIDTH-1];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wr_en   = 1'b0;
    wr_data = '0;
    req     = 1'b0;
    we      = 1'b0;
    adr     = '0;
    wdata   = '0;
    case (state_q)
      FETCH: begin
        req = 1'b1;
        adr = pc_q;
        if (mem.mem_ready) begin
          ir_d    = mem.mem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_inc;
        case (op)
          4'h0:        begin state_d = HALT; pc_d = pc_q; end
          4'h1:        begin wr_en = 1'b1; wr_data = imm; end
          4'h2, 4'h3:  begin state_d = MEM; pc_d = pc_q; end
          4'h4:        begin wr_en = 1'b1; wr_data = rx_v + imm; end
          4'h5:        begin wr_en = 1'b1; wr_data = ry_v + rz_v; end
          4'h6:        begin wr_en = 1'b1; wr_data = ry_v - rz_v; end
          4'h7:        begin wr_en = 1'b1; wr_data = '0 - ry_v; end
          4'h8, 4'h9, 4'hA, 4'hB: if (taken) pc_d = imm;
          4'hC:        pc_d = imm;
          4'hD:        pc_d = rx_v;
          4'hE:        begin wr_en = 1'b1; wr_data = pc_inc; pc_d = imm; end
          default:     ;
        endcase
      end
      MEM: begin
        req   = 1'b1;
        we    = (op == 4'h3);
        adr   = ry_v;
        wdata = we ? rx_v : '0;
        if (mem.mem_ready) begin
          wr_en   = !we;
          wr_data = mem.mem_rdata[WIDTH-1:0];
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      default: ;
    endcase
  end

  // Reset is folded into the outputs, which stay quiet while reset is held even though the state is FETCH.
  assign mem.mem_req   = req & ~reset;
  assign mem.mem_we    = we & ~reset;
  assign mem.mem_adr   = reset ? '0 : adr;
  assign mem.mem_wdata = reset ? '0 : wdata;
  assign halted        = (state_q == HALT) & ~reset;

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset)                          regs_q         <= '0;
    else if (wr_en && rx_idx != '0)     regs_q[rx_idx] <= wr_data;
  end
endmodule

// File: tb/tb_hmmm_core.sv
// Directed bench for hmmm_core: an 8-bit/8-register core with a wait-state memory,
// plus a 12-bit/16-register core covering the parameter sweep.
module tb_hmmm_core;
  logic ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  logic rst_a = 1'b1, rst_b = 1'b1, halted_a, halted_b;

  hmmm_mem_if #(.WIDTH(8),  .IW(15)) ifa();
  hmmm_mem_if #(.WIDTH(12), .IW(20)) ifb();

  hmmm_core #(.WIDTH(8),  .NREGS(8))  dut_a (.ph1(ph1), .reset(rst_a), .mem(ifa.master), .halted(halted_a));
  hmmm_core #(.WIDTH(12), .NREGS(16)) dut_b (.ph1(ph1), .reset(rst_b), .mem(ifb.master), .halted(halted_b));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model A (8-bit core, programmable wait states)
  logic [14:0] mema [256];
  int          wait_a = 0, wcnt_a = 0, cyc = 0, req_cnt_a = 0, viol_a = 0;
  logic        ld_a = 1'b0, clr_a = 1'b0, pend_a = 1'b0;
  logic [7:0]  ld_a_adr = '0;
  logic [14:0] ld_a_dat = '0;
  logic [16:0] snap_a = '0;
  int          flog_a[$];
  int          fcyc_a [256];

  assign ifa.mem_ready = ifa.mem_req && (wcnt_a == wait_a);
  assign ifa.mem_rdata = mema[ifa.mem_adr];

  always @(posedge ph1) begin
    cyc <= cyc + 1;
    if (clr_a) begin
      for (int i = 0; i < 256; i++) mema[i] <= '0;
    end else if (ld_a) begin
      mema[ld_a_adr] <= ld_a_dat;
    end else if (ifa.mem_req) begin
      req_cnt_a <= req_cnt_a + 1;
      if (ifa.mem_ready) begin
        wcnt_a <= 0;
        if (ifa.mem_we) mema[ifa.mem_adr] <= {7'b0, ifa.mem_wdata};
        else begin
          flog_a.push_back(int'(ifa.mem_adr));
          fcyc_a[ifa.mem_adr] <= cyc;
        end
      end else wcnt_a <= wcnt_a + 1;
    end else wcnt_a <= 0;
    if (pend_a && ifa.mem_req && snap_a != {ifa.mem_adr, ifa.mem_we, ifa.mem_wdata})
      viol_a <= viol_a + 1;
    pend_a <= ifa.mem_req && !ifa.mem_ready;
    snap_a <= {ifa.mem_adr, ifa.mem_we, ifa.mem_wdata};
  end

  // ---------------- memory model B (12-bit core, zero wait)
  logic [19:0] memb [4096];
  logic        ld_b = 1'b0, clr_b = 1'b0;
  logic [11:0] ld_b_adr = '0;
  logic [19:0] ld_b_dat = '0;
  int          flog_b[$];

  assign ifb.mem_ready = ifb.mem_req;
  assign ifb.mem_rdata = memb[ifb.mem_adr];

  always @(posedge ph1) begin
    if (clr_b) begin
      for (int i = 0; i < 4096; i++) memb[i] <= '0;
    end else if (ld_b) begin
      memb[ld_b_adr] <= ld_b_dat;
    end else if (ifb.mem_req && ifb.mem_we) begin
      memb[ifb.mem_adr] <= {8'b0, ifb.mem_wdata};
    end else if (ifb.mem_req) begin
      flog_b.push_back(int'(ifb.mem_adr));
    end
  end

  // ---------------- helpers
  function automatic logic [14:0] ia(input logic [3:0] op, input logic [2:0] rx, input logic [7:0] imm);
    return {op, rx, imm};
  endfunction
  function automatic logic [7:0] yz(input logic [2:0] ry, input logic [2:0] rz);
    return {ry, rz, 2'b00};
  endfunction
  function automatic logic [19:0] ib(input logic [3:0] op, input logic [3:0] rx, input logic [11:0] imm);
    return {op, rx, imm};
  endfunction

  task automatic lda(input logic [7:0] a, input logic [14:0] d);
    ld_a_adr = a; ld_a_dat = d; ld_a = 1'b1;
    @(posedge ph1); #1 ld_a = 1'b0;
  endtask
  task automatic ldb(input logic [11:0] a, input logic [19:0] d);
    ld_b_adr = a; ld_b_dat = d; ld_b = 1'b1;
    @(posedge ph1); #1 ld_b = 1'b0;
  endtask
  task automatic clear_a();
    clr_a = 1'b1; @(posedge ph1); #1 clr_a = 1'b0;
  endtask

  task automatic run_a(input string tag, input int budget);
    int n = 0;
    while (!halted_a && n < budget) begin @(negedge ph1); n++; end
    chk(tag, halted_a, 1'b1);
  endtask
  task automatic run_b(input string tag, input int budget);
    int n = 0;
    while (!halted_b && n < budget) begin @(negedge ph1); n++; end
    chk(tag, halted_b, 1'b1);
  endtask

  task automatic chk_log(input string tag, input int got[$], input int base, input int exp[$]);
    chk({tag, "_len"}, got.size() - base, exp.size());
    foreach (exp[i])
      if (base + i < got.size()) chk(tag, got[base + i], exp[i]);
  endtask

  // setn r1,5; setn r2,3; sub r3,r1,r2; setn r4,0x40; storer r3,[r4]; loadr r6,[r4]; halt
  task automatic load_prog1();
    clear_a();
    lda(8'h00, ia(4'h1, 3'd1, 8'h05));
    lda(8'h01, ia(4'h1, 3'd2, 8'h03));
    lda(8'h02, ia(4'h6, 3'd3, yz(3'd1, 3'd2)));
    lda(8'h03, ia(4'h1, 3'd4, 8'h40));
    lda(8'h04, ia(4'h3, 3'd3, yz(3'd4, 3'd0)));
    lda(8'h05, ia(4'h2, 3'd6, yz(3'd4, 3'd0)));
    lda(8'h06, ia(4'h0, 3'd0, 8'h00));
  endtask

  initial begin
    int r, base;
    int e[$];

    repeat (2) @(negedge ph1);
    chk("rst_req",    ifa.mem_req,   1'b0);
    chk("rst_we",     ifa.mem_we,    1'b0);
    chk("rst_adr",    ifa.mem_adr,   8'h00);
    chk("rst_wdata",  ifa.mem_wdata, 8'h00);
    chk("rst_halted", halted_a,      1'b0);

    // ---- zero-wait arithmetic, store and load
    load_prog1();
    wait_a = 0;
    @(negedge ph1); rst_a = 1'b0;
    #1;
    chk("first_req", ifa.mem_req, 1'b1);
    chk("first_adr", ifa.mem_adr, 8'h00);
    run_a("t1_halt", 200);
    chk("t1_store",    mema[8'h40], 15'h0002);
    chk("t1_r3",       dut_a.regs_q[3], 8'h02);
    chk("t1_r6_load",  dut_a.regs_q[6], 8'h02);
    chk("t1_sub_cyc",  fcyc_a[3] - fcyc_a[2], 2);
    chk("t1_load_cyc", fcyc_a[6] - fcyc_a[5], 3);
    r = req_cnt_a;
    repeat (5) @(negedge ph1);
    chk("t1_no_req_after_halt", req_cnt_a - r, 0);
    chk("t1_halted_held", halted_a, 1'b1);

    // ---- same program with three wait states per access
    rst_a = 1'b1;
    @(negedge ph1);
    r = viol_a;
    load_prog1();
    wait_a = 3;
    @(negedge ph1); rst_a = 1'b0;
    run_a("t2_halt", 400);
    chk("t2_stable",   viol_a - r, 0);
    chk("t2_store",    mema[8'h40], 15'h0002);
    chk("t2_r3",       dut_a.regs_q[3], 8'h02);
    chk("t2_r6_load",  dut_a.regs_q[6], 8'h02);
    chk("t2_sub_cyc",  fcyc_a[3] - fcyc_a[2], 5);
    chk("t2_load_cyc", fcyc_a[6] - fcyc_a[5], 9);

    // ---- branches, call with link, jump register
    rst_a = 1'b1;
    @(negedge ph1);
    clear_a();
    lda(8'h00, ia(4'h1, 3'd1, 8'h80));
    lda(8'h01, ia(4'hB, 3'd1, 8'h10));
    lda(8'h10, ia(4'hE, 3'd5, 8'h20));
    lda(8'h20, ia(4'hD, 3'd5, 8'h00));
    lda(8'h11, ia(4'h1, 3'd7, 8'h33));
    lda(8'h12, ia(4'h8, 3'd1, 8'h30));
    lda(8'h13, ia(4'hA, 3'd1, 8'h30));
    lda(8'h14, ia(4'h9, 3'd1, 8'h18));
    wait_a = 0;
    base = flog_a.size();
    @(negedge ph1); rst_a = 1'b0;
    run_a("t3_halt", 200);
    chk("t3_r5_link", dut_a.regs_q[5], 8'h11);
    chk("t3_r7",      dut_a.regs_q[7], 8'h33);
    e = '{0, 32'h01, 32'h10, 32'h20, 32'h11, 32'h12, 32'h13, 32'h14, 32'h18};
    chk_log("t3_fetch", flog_a, base, e);

    // ---- r0 hardwired, arithmetic and PC wrap
    rst_a = 1'b1;
    @(negedge ph1);
    clear_a();
    lda(8'h00, ia(4'h9, 3'd2, 8'h20));
    lda(8'h01, ia(4'h1, 3'd1, 8'h07));
    lda(8'h02, ia(4'h1, 3'd0, 8'hFF));
    lda(8'h03, ia(4'h5, 3'd1, yz(3'd0, 3'd0)));
    lda(8'h04, ia(4'h1, 3'd2, 8'h01));
    lda(8'h05, ia(4'h4, 3'd2, 8'hFF));
    lda(8'h06, ia(4'h4, 3'd2, 8'hFF));
    lda(8'h07, ia(4'hE, 3'd0, 8'hFF));
    lda(8'hFF, ia(4'hF, 3'd0, 8'h00));
    base = flog_a.size();
    @(negedge ph1); rst_a = 1'b0;
    run_a("t4_halt", 200);
    chk("t4_r0",     dut_a.regs_q[0], 8'h00);
    chk("t4_r1_add", dut_a.regs_q[1], 8'h00);
    chk("t4_r2",     dut_a.regs_q[2], 8'hFF);
    e = '{0, 1, 2, 3, 4, 5, 6, 7, 32'hFF, 0, 32'h20};
    chk_log("t4_fetch", flog_a, base, e);

    // ---- reset while a store is stalled
    rst_a = 1'b1;
    @(negedge ph1);
    clear_a();
    lda(8'h00, ia(4'h1, 3'd1, 8'h55));
    lda(8'h01, ia(4'h1, 3'd2, 8'h40));
    lda(8'h02, ia(4'h3, 3'd1, yz(3'd2, 3'd0)));
    wait_a = 10;
    @(negedge ph1); rst_a = 1'b0;
    r = 0;
    while (!(ifa.mem_req && ifa.mem_we) && r < 100) begin @(negedge ph1); r++; end
    chk("t5_store_seen", ifa.mem_req && ifa.mem_we, 1'b1);
    repeat (2) @(negedge ph1);
    chk("t5_wadr",  ifa.mem_adr,   8'h40);
    chk("t5_wdata", ifa.mem_wdata, 8'h55);
    rst_a = 1'b1;
    #1;
    chk("t5_req_drop", ifa.mem_req, 1'b0);
    chk("t5_we_drop",  ifa.mem_we,  1'b0);
    chk("t5_adr_zero", ifa.mem_adr, 8'h00);
    repeat (12) @(negedge ph1);
    chk("t5_no_write", mema[8'h40], 15'h0000);
    chk("t5_r1_reset", dut_a.regs_q[1], 8'h00);
    rst_a = 1'b0;
    #1;
    chk("t5_refetch_req", ifa.mem_req, 1'b1);
    chk("t5_refetch_adr", ifa.mem_adr, 8'h00);
    chk("t5_refetch_we",  ifa.mem_we,  1'b0);
    @(negedge ph1); rst_a = 1'b1;

    // ---- WIDTH=12, NREGS=16
    clr_b = 1'b1; @(posedge ph1); #1 clr_b = 1'b0;
    ldb(12'h000, ib(4'h9, 4'd15, 12'h100));
    ldb(12'h001, ib(4'h1, 4'd15, 12'h800));
    ldb(12'h002, ib(4'h2, 4'd15, 12'hF00));
    ldb(12'h003, ib(4'hC, 4'd0,  12'hFFF));
    ldb(12'hFFF, ib(4'hF, 4'd0,  12'h000));
    ldb(12'h800, 20'hF5ABC);
    @(negedge ph1); rst_b = 1'b0;
    run_b("t6_halt", 200);
    chk("t6_r15_load", dut_b.regs_q[15], 12'hABC);
    e = '{0, 1, 2, 32'h800, 3, 32'hFFF, 0, 32'h100};
    chk_log("t6_fetch", flog_b, 0, e);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
